spi_peripheral_os: RTL and testbench

//  SPI peripheral, single clock domain: SCLK/CS_n/PICO oversampled on i_clk, edge-detected, no SPI-clock flops.

---
 rtl/spi_periph_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 41 ++++
 rtl/spi_peripheral_os.sv | 263 ++++++++++++++++++++++++++
 tb/tb_spi_peripheral_os.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_periph_pkg.sv
// spi_periph_pkg: shared types and edge-decode helpers for the oversampled SPI peripheral.
//   state_e        : peripheral frame FSM states
//   lead_is_rise() : 1 when the leading SCLK edge is the rising edge (CPOL=0)
//   sample_on_lead(): 1 when PICO is sampled on the leading edge (CPHA=0)
package spi_periph_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_e;

    function automatic logic lead_is_rise(input logic cpol);
        return !cpol;
    endfunction

    function automatic logic sample_on_lead(input logic cpha);
        return !cpha;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous pin plus a history
// flop, giving the synchronised level and one-cycle rise/fall pulses.
//   i_clk   in  : sampling clock
//   i_rst   in  : synchronous active-high reset (chain and history load RST_VAL)
//   i_async in  : asynchronous input pin
//   o_sync  out : synchronised level
//   o_rise  out : one-cycle pulse on a synchronised 0->1 transition
//   o_fall  out : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge
    import spi_periph_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchroniser chain and one-cycle history of the synchronised level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];
    assign o_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign o_fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_peripheral_os.sv
// spi_peripheral_os: SPI peripheral that oversamples SCLK/CS_n/PICO on i_clk
// (no flops clocked by SCLK). All four SPI modes, WORD_W-bit words, back-to-back
// words under one CS_n. Tx through a one-word valid/ready holding register,
// Rx as a one-cycle valid per completed word.
// Optional build macro: SPI_PERIPH_ERR_EN adds o_txUnderrun / i_errClr.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_txValid/o_txReady : Tx holding-register handshake, i_txData Tx word
//   o_rxValid/o_rxData  : Rx word pulse and last completed word
//   o_busy              : frame in progress (FSM in ACTIVE)
//   i_SPI_CLK/PICO/CS_n : asynchronous SPI pins from the controller
//   o_SPI_POCI(_oe)     : peripheral data out and its output enable
//   o_txUnderrun        : (SPI_PERIPH_ERR_EN) sticky, a word load used TX_FILL
//   i_errClr            : (SPI_PERIPH_ERR_EN) clears o_txUnderrun
module spi_peripheral_os
    import spi_periph_pkg::*;
#(
    parameter int          WORD_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] TX_FILL     = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_txValid,
    output logic              o_txReady,
    input  logic [WORD_W-1:0] i_txData,
    output logic              o_rxValid,
    output logic [WORD_W-1:0] o_rxData,
    output logic              o_busy,
    input  logic              i_SPI_CLK,
    input  logic              i_SPI_PICO,
    input  logic              i_SPI_CS_n,
    output logic              o_SPI_POCI,
    output logic              o_SPI_POCI_oe
`ifdef SPI_PERIPH_ERR_EN
    ,
    output logic              o_txUnderrun,
    input  logic              i_errClr
`endif
);

    localparam int                CNT_W      = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WORD_W - 1);
    localparam logic              LEAD_RISE  = lead_is_rise(CPOL);
    localparam logic              SAMPLE_LD  = sample_on_lead(CPHA);
    localparam int                TX_BIT     = MSB_FIRST ? WORD_W - 1 : 0;
    localparam logic [WORD_W-1:0] FILL_WORD  = TX_FILL[WORD_W-1:0];
    // After reset the synchronisers hold their reset value, not the pin; wait
    // until the whole chain plus history reflects the real CS_n level.
    localparam logic [2:0]        SETTLE_CYC = 3'(SYNC_STAGES + 1);

    // Synchronised pins and edge pulses
    logic sclk_s, sclk_rise_s, sclk_fall_s, sclk_edge_s;
    logic cs_n_s, cs_rise_s, cs_fall_s;
    logic [SYNC_STAGES-1:0] pico_sync_q;
    logic pico_s;
    logic lead_s, trail_s, sample_s, shift_s;

    // FSM and datapath state
    state_e              state_q, state_d;
    logic [2:0]          settle_q;
    logic                settle_done_s;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   rx_shift_q, rx_shift_d, rx_next_s;
    logic [WORD_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                word_done_q, word_done_d;
    logic [WORD_W-1:0]   tx_shift_q, tx_shift_d, tx_shifted_s;
    logic                load_s;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                tx_ready_q;
    logic                wr_s;
    logic                busy_q;
    logic                poci_q;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_SPI_CLK),
        .o_sync  (sclk_s),
        .o_rise  (sclk_rise_s),
        .o_fall  (sclk_fall_s)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_SPI_CS_n),
        .o_sync  (cs_n_s),
        .o_rise  (cs_rise_s),
        .o_fall  (cs_fall_s)
    );

    // PICO synchroniser, same depth as SCLK so data and its edge stay aligned
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pico_sync_q <= '0;
        end else begin
            pico_sync_q <= {pico_sync_q[SYNC_STAGES-2:0], i_SPI_PICO};
        end
    end

    assign pico_s      = pico_sync_q[SYNC_STAGES-1];
    assign sclk_edge_s = sclk_rise_s | sclk_fall_s;
    // An edge is leading when the new SCLK level is the non-idle level
    assign lead_s      = sclk_edge_s & (sclk_s == LEAD_RISE);
    assign trail_s     = sclk_edge_s & (sclk_s != LEAD_RISE);
    assign sample_s    = SAMPLE_LD ? lead_s  : trail_s;
    assign shift_s     = SAMPLE_LD ? trail_s : lead_s;

    assign settle_done_s = (settle_q == SETTLE_CYC);
    assign rx_next_s     = MSB_FIRST ? {rx_shift_q[WORD_W-2:0], pico_s}
                                     : {pico_s, rx_shift_q[WORD_W-1:1]};
    assign tx_shifted_s  = MSB_FIRST ? {tx_shift_q[WORD_W-2:0], 1'b0}
                                     : {1'b0, tx_shift_q[WORD_W-1:1]};

    // Frame FSM, bit counter, Rx assembly and Tx shift/load decisions
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        word_done_d = word_done_q;
        tx_shift_d  = tx_shift_q;
        load_s      = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (settle_done_s && cs_n_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            IDLE: begin
                if (cs_fall_s) begin
                    state_d     = ACTIVE;
                    bit_cnt_d   = '0;
                    word_done_d = 1'b0;
                    // CPHA=0 must present the first bit before the first SCLK edge
                    load_s      = !CPHA;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    // Partial words are dropped; bit_cnt restarts on the next csFall
                    state_d = IDLE;
                end else begin
                    if (sample_s) begin
                        rx_shift_d = rx_next_s;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d   = '0;
                            rx_data_d   = rx_next_s;
                            rx_valid_d  = 1'b1;
                            word_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        rx_shift_d = rx_shift_q;
                    end
                    if (shift_s) begin
                        word_done_d = 1'b0;
                        if (CPHA ? (bit_cnt_q == '0) : word_done_q) begin
                            load_s = 1'b1;
                        end else begin
                            tx_shift_d = tx_shifted_s;
                        end
                    end else begin
                        tx_shift_d = tx_shift_d;
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
        if (load_s) begin
            tx_shift_d = hold_valid_q ? hold_q : FILL_WORD;
        end else begin
            tx_shift_d = tx_shift_d;
        end
    end

    // Holding register: a write and a load in the same cycle leave it valid
    always_comb begin
        wr_s   = i_txValid & tx_ready_q;
        hold_d = wr_s ? i_txData : hold_q;
        if (wr_s) begin
            hold_valid_d = 1'b1;
        end else if (load_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= WAIT_IDLE;
            settle_q     <= 3'd0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            word_done_q  <= 1'b0;
            tx_shift_q   <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            poci_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_done_s ? settle_q : settle_q + 3'd1;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            word_done_q  <= word_done_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_ready_q   <= !hold_valid_d;
            busy_q       <= (state_d == ACTIVE);
            poci_q       <= (state_d == ACTIVE) ? tx_shift_d[TX_BIT] : 1'b0;
        end
    end

    assign o_txReady     = tx_ready_q;
    assign o_rxValid     = rx_valid_q;
    assign o_rxData      = rx_data_q;
    assign o_busy        = busy_q;
    assign o_SPI_POCI    = poci_q;
    assign o_SPI_POCI_oe = busy_q;

`ifdef SPI_PERIPH_ERR_EN
    logic underrun_q;

    // Sticky underrun flag; a new underrun beats a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            underrun_q <= 1'b0;
        end else if (load_s && !hold_valid_q) begin
            underrun_q <= 1'b1;
        end else if (i_errClr) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_q;
        end
    end

    assign o_txUnderrun = underrun_q;
`endif

endmodule

// File: tb/tb_spi_peripheral_os.sv
// tb_spi_peripheral_os: directed bench for spi_peripheral_os with three instances:
//   A: mode 0, 8-bit, MSB first, TX_FILL=0xFF
//   B: mode 3, 8-bit, MSB first, TX_FILL=0x00
//   C: mode 1, 16-bit, LSB first, TX_FILL=0x0000
// One SPI controller model drives whichever instance 'sel' points at.
module tb_spi_peripheral_os;

    localparam int HALF = 8;
    localparam int GAP  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        sclk_ph;
    logic        cs_n;
    logic        pico;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        err_clr;

    logic a_sclk, b_sclk, c_sclk, a_cs, b_cs, c_cs, a_txv, b_txv, c_txv;
    assign a_sclk = (sel == 0) ? sclk_ph : 1'b0;
    assign b_sclk = (sel == 1) ? ~sclk_ph : 1'b1;
    assign c_sclk = (sel == 2) ? sclk_ph : 1'b0;
    assign a_cs   = (sel == 0) ? cs_n : 1'b1;
    assign b_cs   = (sel == 1) ? cs_n : 1'b1;
    assign c_cs   = (sel == 2) ? cs_n : 1'b1;
    assign a_txv  = (sel == 0) & tx_valid;
    assign b_txv  = (sel == 1) & tx_valid;
    assign c_txv  = (sel == 2) & tx_valid;

    logic        a_ready, a_rxv, a_busy, a_poci, a_oe, a_unr;
    logic [7:0]  a_rxd;
    logic        b_ready, b_rxv, b_busy, b_poci, b_oe, b_unr;
    logic [7:0]  b_rxd;
    logic        c_ready, c_rxv, c_busy, c_poci, c_oe, c_unr;
    logic [15:0] c_rxd;

    logic poci_obs;
    assign poci_obs = (sel == 0) ? a_poci : ((sel == 1) ? b_poci : c_poci);

    spi_peripheral_os #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                        .SYNC_STAGES(2), .TX_FILL(32'h0000_00FF)) u_a (
        .i_clk(clk), .i_rst(rst), .i_txValid(a_txv), .o_txReady(a_ready),
        .i_txData(tx_data[7:0]), .o_rxValid(a_rxv), .o_rxData(a_rxd), .o_busy(a_busy),
        .i_SPI_CLK(a_sclk), .i_SPI_PICO(pico), .i_SPI_CS_n(a_cs),
        .o_SPI_POCI(a_poci), .o_SPI_POCI_oe(a_oe)
`ifdef SPI_PERIPH_ERR_EN
        , .o_txUnderrun(a_unr), .i_errClr(err_clr)
`endif
    );

    spi_peripheral_os #(.WORD_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1),
                        .SYNC_STAGES(2), .TX_FILL(32'h0000_0000)) u_b (
        .i_clk(clk), .i_rst(rst), .i_txValid(b_txv), .o_txReady(b_ready),
        .i_txData(tx_data[7:0]), .o_rxValid(b_rxv), .o_rxData(b_rxd), .o_busy(b_busy),
        .i_SPI_CLK(b_sclk), .i_SPI_PICO(pico), .i_SPI_CS_n(b_cs),
        .o_SPI_POCI(b_poci), .o_SPI_POCI_oe(b_oe)
`ifdef SPI_PERIPH_ERR_EN
        , .o_txUnderrun(b_unr), .i_errClr(err_clr)
`endif
    );

    spi_peripheral_os #(.WORD_W(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0),
                        .SYNC_STAGES(2), .TX_FILL(32'h0000_0000)) u_c (
        .i_clk(clk), .i_rst(rst), .i_txValid(c_txv), .o_txReady(c_ready),
        .i_txData(tx_data[15:0]), .o_rxValid(c_rxv), .o_rxData(c_rxd), .o_busy(c_busy),
        .i_SPI_CLK(c_sclk), .i_SPI_PICO(pico), .i_SPI_CS_n(c_cs),
        .o_SPI_POCI(c_poci), .o_SPI_POCI_oe(c_oe)
`ifdef SPI_PERIPH_ERR_EN
        , .o_txUnderrun(c_unr), .i_errClr(err_clr)
`endif
    );

`ifndef SPI_PERIPH_ERR_EN
    assign a_unr = 1'b0;
    assign b_unr = 1'b0;
    assign c_unr = 1'b0;
`endif

    // Rx word monitors
    int          a_rx_cnt = 0, b_rx_cnt = 0, c_rx_cnt = 0;
    logic [31:0] a_rx_last = '0, b_rx_last = '0, c_rx_last = '0;
    always @(negedge clk) begin
        if (a_rxv) begin a_rx_cnt <= a_rx_cnt + 1; a_rx_last <= {24'd0, a_rxd}; end
        if (b_rxv) begin b_rx_cnt <= b_rx_cnt + 1; b_rx_last <= {24'd0, b_rxd}; end
        if (c_rxv) begin c_rx_cnt <= c_rx_cnt + 1; c_rx_last <= {16'd0, c_rxd}; end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wr_hold(input logic [31:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic cs_hi();
        cs_n = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    // One word (or nbits of it) from the controller; inj raises i_txValid in the
    // exact cycle the CPHA=1 peripheral loads its first word.
    task automatic xfer(input int nbits, input logic [31:0] tx, input bit inj,
                        output logic [31:0] rx);
        int w;
        bit cpha;
        bit msb;
        int idx;
        w    = (sel == 2) ? 16 : 8;
        cpha = (sel != 0);
        msb  = (sel != 2);
        rx   = '0;
        for (int k = 0; k < nbits; k++) begin
            idx = msb ? (w - 1 - k) : k;
            if (!cpha) begin
                pico = tx[idx];
                repeat (HALF) @(negedge clk);
                sclk_ph = 1'b1;
                rx[idx] = poci_obs;
                repeat (HALF) @(negedge clk);
                sclk_ph = 1'b0;
            end else begin
                sclk_ph = 1'b1;
                pico    = tx[idx];
                if (inj && k == 0) begin
                    @(negedge clk);
                    @(negedge clk);
                    tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                    repeat (HALF - 3) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
                sclk_ph = 1'b0;
                rx[idx] = poci_obs;
                repeat (HALF) @(negedge clk);
            end
        end
        if (!cpha) repeat (HALF) @(negedge clk);
    endtask

    logic [31:0] r;
    int          base;

    initial begin
        rst = 1'b1; sel = 0; sclk_ph = 1'b0; cs_n = 1'b1; pico = 1'b0;
        tx_valid = 1'b0; tx_data = '0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_a", {31'd0, a_ready}, 32'd1);
        check("rst_rxv_a",   {31'd0, a_rxv},   32'd0);
        check("rst_rxd_a",   {24'd0, a_rxd},   32'd0);
        check("rst_busy_a",  {31'd0, a_busy},  32'd0);
        check("rst_poci_a",  {31'd0, a_poci},  32'd0);
        check("rst_oe_a",    {31'd0, a_oe},    32'd0);
        check("rst_ready_c", {31'd0, c_ready}, 32'd1);
        check("rst_unr_a",   {31'd0, a_unr},   32'd0);
        repeat (10) @(negedge clk);

        // Mode 0: hold 0x3C out, 0xA5 in
        sel = 0;
        wr_hold(32'h3C);
        check("a_ready_full", {31'd0, a_ready}, 32'd0);
        cs_lo();
        check("a_busy_on", {31'd0, a_busy}, 32'd1);
        check("a_oe_on",   {31'd0, a_oe},   32'd1);
        xfer(8, 32'hA5, 1'b0, r);
        check("a_poci_3c", r, 32'h3C);
        check("a_rx_a5",   a_rx_last, 32'hA5);
        check("a_rx_cnt1", 32'(a_rx_cnt), 32'd1);
        cs_hi();
        check("a_busy_off", {31'd0, a_busy}, 32'd0);
        check("a_oe_off",   {31'd0, a_oe},   32'd0);
        check("a_ready_mt", {31'd0, a_ready}, 32'd1);
`ifdef SPI_PERIPH_ERR_EN
        check("a_unr_set", {31'd0, a_unr}, 32'd1);
        @(negedge clk); err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
        check("a_unr_clr", {31'd0, a_unr}, 32'd0);
`endif
        // Mode 0 underrun: empty hold gives TX_FILL
        cs_lo();
        xfer(8, 32'h0F, 1'b0, r);
        check("a_poci_fill", r, 32'hFF);
        check("a_rx_0f",     a_rx_last, 32'h0F);
        cs_hi();
`ifdef SPI_PERIPH_ERR_EN
        check("a_unr_set2", {31'd0, a_unr}, 32'd1);
`endif

        // Mode 3: two words in one frame
        sel = 1;
        wr_hold(32'h12);
        cs_lo();
        xfer(8, 32'hC3, 1'b0, r);
        check("b_poci_12",  r, 32'h12);
        check("b_rx_c3",    b_rx_last, 32'hC3);
        check("b_ready_up", {31'd0, b_ready}, 32'd1);
        wr_hold(32'h34);
        check("b_ready_dn", {31'd0, b_ready}, 32'd0);
        xfer(8, 32'h96, 1'b0, r);
        check("b_poci_34",  r, 32'h34);
        check("b_rx_96",    b_rx_last, 32'h96);
        check("b_rx_cnt2",  32'(b_rx_cnt), 32'd2);
        cs_hi();
        check("b_busy_off", {31'd0, b_busy}, 32'd0);

        // CPHA=1 partial word is discarded
        cs_lo();
        xfer(5, 32'hF0, 1'b0, r);
        cs_hi();
        check("b_partial", 32'(b_rx_cnt), 32'd2);
        cs_lo();
        xfer(8, 32'h5A, 1'b0, r);
        check("b_rx_5a",   b_rx_last, 32'h5A);
        check("b_rx_cnt3", 32'(b_rx_cnt), 32'd3);
        check("b_poci_0",  r, 32'h00);
        cs_hi();

        // Reset in the middle of a frame with CS_n held low
        sel = 0;
        wr_hold(32'h66);
        cs_lo();
        xfer(3, 32'hFF, 1'b0, r);
        base = a_rx_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mr_busy",  {31'd0, a_busy},  32'd0);
        check("mr_oe",    {31'd0, a_oe},    32'd0);
        check("mr_ready", {31'd0, a_ready}, 32'd1);
        check("mr_rxd",   {24'd0, a_rxd},   32'd0);
        xfer(8, 32'h77, 1'b0, r);
        check("mr_ignore_cnt",  32'(a_rx_cnt), 32'(base));
        check("mr_ignore_busy", {31'd0, a_busy}, 32'd0);
        cs_hi();
        wr_hold(32'h5C);
        cs_lo();
        xfer(8, 32'h3A, 1'b0, r);
        check("mr_poci_5c", r, 32'h5C);
        check("mr_rx_3a",   a_rx_last, 32'h3A);
        check("mr_rx_cnt",  32'(a_rx_cnt), 32'(base + 1));
        cs_hi();

        // 16-bit, LSB first, mode 1
        sel = 2;
        wr_hold(32'hA55A);
        cs_lo();
        xfer(16, 32'hBEEF, 1'b0, r);
        check("c_poci_a55a", r, 32'hA55A);
        check("c_rx_beef",   c_rx_last, 32'hBEEF);
        cs_hi();
        check("c_ready_mt",  {31'd0, c_ready}, 32'd1);
        // Write lands in the same cycle as the load of an empty hold
        tx_data = 32'h1357;
        cs_lo();
        xfer(16, 32'h0001, 1'b1, r);
        check("c_poci_fill", r, 32'h0000);
        check("c_hold_kept", {31'd0, c_ready}, 32'd0);
        check("c_rx_0001",   c_rx_last, 32'h0001);
        cs_hi();
        cs_lo();
        xfer(16, 32'h8000, 1'b0, r);
        check("c_poci_1357", r, 32'h1357);
        check("c_rx_8000",   c_rx_last, 32'h8000);
        check("c_rx_cnt",    32'(c_rx_cnt), 32'd3);
        cs_hi();
        check("c_ready_end", {31'd0, c_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
